cache_controller: RTL and testbench
===================================

# cache_controller

Direct-mapped, write-back, write-allocate cache controller sitting between the CPU load/store port and main memory. It is the initiator for the status/tag RAM and data RAM pair: it drives their address, read enable and write enable, and consumes their registered outputs one cycle later. On a miss it writes back a dirty victim line and refills from memory over a valid/ready line interface. Line size is 128 bits (4 words); one outstanding CPU request at a time.

## Interface
- TAG_LEN, 13, tag width.
- INDEX_LEN, 10, index width (1024 lines).
- OFFSET_LEN, 4, byte offset width (16-byte line).
- ADDR_LEN, TAG_LEN+INDEX_LEN+OFFSET_LEN (27), CPU byte-address width.
- LINE_W, 32*2**(OFFSET_LEN-2) (128), line width.

- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- cpu_req_valid  in  1  CPU request present.
- cpu_req_we  in  1  1 = store, 0 = load.
- cpu_req_addr  in  ADDR_LEN  byte address; bits [1:0] ignored.
- cpu_req_wdata  in  32  store word.
- cpu_req_ready  out  1  controller accepts a request this cycle.
- cpu_resp_valid  out  1  one-cycle completion pulse (loads and stores).
- cpu_resp_rdata  out  32  load word; 0 for stores.
- ram_addr  out  INDEX_LEN  shared index for both RAMs.
- tag_re, tag_we  out  1  status/tag RAM enables.
- tag_wdata  out  TAG_LEN  tag to write.
- status_wdata  out  3  status to write: bit0 valid, bit1 dirty, bit2 reserved (written 0).
- tag_rdata  in  TAG_LEN, status_rdata  in  3  registered RAM outputs.
- data_re, data_we  out  1  data RAM enables.
- data_wdata  out  LINE_W, data_rdata  in  LINE_W  line in/out; word w at bits [32w+31:32w].
- mem_req_valid  out  1, mem_req_ready  in  1  memory request handshake.
- mem_req_we  out  1  1 = line write-back, 0 = line read.
- mem_req_addr  out  TAG_LEN+INDEX_LEN  line address ({tag,index}).
- mem_req_wdata  out  LINE_W  write-back line.
- mem_resp_valid  in  1, mem_resp_rdata  in  LINE_W  refill line, one-cycle pulse.

## Operation
- States: IDLE, CHECK, WB, REFILL_REQ, REFILL_WAIT.
- IDLE: cpu_req_ready=1. On valid&ready: latch we/addr/wdata; drive ram_addr=addr[13:4], tag_re=data_re=1 → CHECK.
- CHECK: RAM outputs valid. hit = status_rdata[0] & (tag_rdata==req tag). Word select = addr[3:2].
  - Load hit: cpu_resp_valid=1, rdata = selected word → IDLE.
  - Store hit: data_we=tag_we=1, data_wdata = data_rdata with selected word replaced, status=3'b011, same tag; cpu_resp_valid=1 → IDLE.
  - Miss, victim valid&dirty: capture victim line and tag → WB.
  - Miss otherwise → REFILL_REQ.
- WB: mem_req_valid=1, we=1, addr={victim tag,index}, wdata=victim line; on mem_req_ready → REFILL_REQ. Write completes at handshake; no response expected.
- REFILL_REQ: mem_req_valid=1, we=0, addr={req tag,index}; on ready → REFILL_WAIT.
- REFILL_WAIT: on mem_resp_valid: data_we=tag_we=1, line = refill line (store word merged if store), tag = req tag, status = 3'b001 load / 3'b011 store; cpu_resp_valid=1, rdata = selected word of refill line (load) → IDLE.
- mem_resp_valid outside REFILL_WAIT is ignored. ram_addr holds req index in all non-IDLE states.

## Timing
- Reset: state IDLE; cpu_req_ready=1 on the first cycle after reset; all other outputs 0.
- Load/store hit: accept cycle N, cpu_resp_valid in N+1, next request accepted in N+2.
- Clean miss: mem_req_valid from N+2; response the cycle mem_resp_valid is seen.
- mem_req_valid/we/addr/wdata held stable from assertion until the ready cycle.
- cpu_req_ready=0 in every state except IDLE.
- RAM writes issued in CHECK or REFILL_WAIT take effect at that clock edge; a request accepted the next cycle reads the new contents.
- Reset mid-transaction: return to IDLE next cycle, drop any pending memory transaction without completing it; the memory side is reset on the same rst.

## Structure
- Package cache_pkg: TAG_LEN/INDEX_LEN/OFFSET_LEN defaults, STATUS_VALID=0/STATUS_DIRTY=1 bit positions, state encoding.
- Sub-module cache_line_merge (combinational): line, word index, word → merged line; used by both the store-hit and refill paths.

## Test plan
- After reset, load 0x0000104 → mem_req read, addr 0x000010; respond line 0x44444444_33333333_22222222_11111111 → cpu_resp_rdata 0x22222222.
- Load 0x0000108 → cpu_resp_valid the cycle after accept, rdata 0x33333333, no mem_req.
- Store 0xDEADBEEF to 0x000010C (hit) → status written 3'b011; load 0x000010C returns 0xDEADBEEF.
- Load 0x0004104 (tag 1, index 0x010) → write-back addr 0x000010 with wdata[127:96]=0xDEADBEEF, then read addr 0x000410.
- Hold mem_req_ready low 5 cycles → mem_req_* stable, cpu_req_ready=0 throughout.
- Assert rst in REFILL_WAIT → next cycle all outputs 0, cpu_req_ready=1; late mem_resp_valid produces no RAM write or response.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared geometry defaults, status-bit layout and FSM encoding for the cache controller.
package cache_pkg;

  localparam int unsigned DEFAULT_TAG_LEN    = 13;
  localparam int unsigned DEFAULT_INDEX_LEN  = 10;
  localparam int unsigned DEFAULT_OFFSET_LEN = 4;

  localparam int unsigned STATUS_VALID = 0;
  localparam int unsigned STATUS_DIRTY = 1;
  localparam int unsigned STATUS_W     = 3;

  localparam logic [2:0] StIdle       = 3'd0;
  localparam logic [2:0] StCheck      = 3'd1;
  localparam logic [2:0] StWb         = 3'd2;
  localparam logic [2:0] StRefillReq  = 3'd3;
  localparam logic [2:0] StRefillWait = 3'd4;

  // Status word for a freshly written line; the reserved bit is always written 0.
  function automatic logic [STATUS_W-1:0] status_word(input logic dirty);
    logic [STATUS_W-1:0] s;
    s               = '0;
    s[STATUS_VALID] = 1'b1;
    s[STATUS_DIRTY] = dirty;
    return s;
  endfunction

endpackage

// File: rtl/cache_line_merge.sv
// Replaces one 32-bit word of a cache line; shared by the store-hit and refill paths.
module cache_line_merge #(
  parameter int unsigned OFFSET_LEN = 4,
  localparam int unsigned LINE_W    = 32 * (2 ** (OFFSET_LEN - 2)),
  localparam int unsigned WSEL_W    = OFFSET_LEN - 2
) (
  input  logic [LINE_W-1:0] line_i,
  input  logic [WSEL_W-1:0] word_idx_i,
  input  logic [31:0]       word_i,
  output logic [LINE_W-1:0] line_o
);

  always_comb begin
    line_o                            = line_i;
    line_o[{word_idx_i, 5'b0} +: 32] = word_i;
  end

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped write-back / write-allocate cache controller driving external tag and data RAMs
// with one-cycle registered read latency, plus a line-wide memory port.
module cache_controller
  import cache_pkg::*;
#(
  parameter int unsigned TAG_LEN    = DEFAULT_TAG_LEN,
  parameter int unsigned INDEX_LEN  = DEFAULT_INDEX_LEN,
  parameter int unsigned OFFSET_LEN = DEFAULT_OFFSET_LEN,
  localparam int unsigned ADDR_LEN  = TAG_LEN + INDEX_LEN + OFFSET_LEN,
  localparam int unsigned LINE_W    = 32 * (2 ** (OFFSET_LEN - 2)),
  localparam int unsigned WSEL_W    = OFFSET_LEN - 2
) (
  input  logic                         clk,
  input  logic                         rst,
  // CPU side
  input  logic                         cpu_req_valid,
  input  logic                         cpu_req_we,
  input  logic [ADDR_LEN-1:0]          cpu_req_addr,
  input  logic [31:0]                  cpu_req_wdata,
  output logic                         cpu_req_ready,
  output logic                         cpu_resp_valid,
  output logic [31:0]                  cpu_resp_rdata,
  // Tag / status / data RAMs
  output logic [INDEX_LEN-1:0]         ram_addr,
  output logic                         tag_re,
  output logic                         tag_we,
  output logic [TAG_LEN-1:0]           tag_wdata,
  output logic [STATUS_W-1:0]          status_wdata,
  input  logic [TAG_LEN-1:0]           tag_rdata,
  input  logic [STATUS_W-1:0]          status_rdata,
  output logic                         data_re,
  output logic                         data_we,
  output logic [LINE_W-1:0]            data_wdata,
  input  logic [LINE_W-1:0]            data_rdata,
  // Memory side
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic                         mem_req_we,
  output logic [TAG_LEN+INDEX_LEN-1:0] mem_req_addr,
  output logic [LINE_W-1:0]            mem_req_wdata,
  input  logic                         mem_resp_valid,
  input  logic [LINE_W-1:0]            mem_resp_rdata
);

  logic [2:0]          state_q, state_d;
  logic                req_we_q, req_we_d;
  logic [ADDR_LEN-1:0] req_addr_q, req_addr_d;
  logic [31:0]         req_wdata_q, req_wdata_d;
  logic [LINE_W-1:0]   victim_line_q, victim_line_d;
  logic [TAG_LEN-1:0]  victim_tag_q, victim_tag_d;

  logic [TAG_LEN-1:0]   req_tag;
  logic [INDEX_LEN-1:0] req_index;
  logic [WSEL_W-1:0]    req_word;

  assign req_tag   = req_addr_q[ADDR_LEN-1 -: TAG_LEN];
  assign req_index = req_addr_q[OFFSET_LEN +: INDEX_LEN];
  assign req_word  = req_addr_q[2 +: WSEL_W];

  logic hit, victim_dirty;
  assign hit          = status_rdata[STATUS_VALID] && (tag_rdata == req_tag);
  assign victim_dirty = status_rdata[STATUS_VALID] && status_rdata[STATUS_DIRTY];

  // The merge base is the resident line in CHECK and the incoming refill line in REFILL_WAIT.
  logic [LINE_W-1:0] merge_base, merged_line;
  logic [31:0]       sel_word;

  assign merge_base = (state_q == StRefillWait) ? mem_resp_rdata : data_rdata;
  assign sel_word   = merge_base[{req_word, 5'b0} +: 32];

  cache_line_merge #(
    .OFFSET_LEN (OFFSET_LEN)
  ) u_merge (
    .line_i     (merge_base),
    .word_idx_i (req_word),
    .word_i     (req_wdata_q),
    .line_o     (merged_line)
  );

  // Byte-offset bits and the reserved status bit carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{cpu_req_addr[1:0], req_addr_q[1:0], status_rdata[STATUS_W-1]};

  always_comb begin
    state_d       = state_q;
    req_we_d      = req_we_q;
    req_addr_d    = req_addr_q;
    req_wdata_d   = req_wdata_q;
    victim_line_d = victim_line_q;
    victim_tag_d  = victim_tag_q;

    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_rdata = '0;
    ram_addr       = req_index;
    tag_re         = 1'b0;
    tag_we         = 1'b0;
    tag_wdata      = '0;
    status_wdata   = '0;
    data_re        = 1'b0;
    data_we        = 1'b0;
    data_wdata     = '0;
    mem_req_valid  = 1'b0;
    mem_req_we     = 1'b0;
    mem_req_addr   = '0;
    mem_req_wdata  = '0;

    unique case (state_q)
      StIdle: begin
        cpu_req_ready = 1'b1;
        ram_addr      = '0;
        if (cpu_req_valid) begin
          req_we_d    = cpu_req_we;
          req_addr_d  = cpu_req_addr;
          req_wdata_d = cpu_req_wdata;
          ram_addr    = cpu_req_addr[OFFSET_LEN +: INDEX_LEN];
          tag_re      = 1'b1;
          data_re     = 1'b1;
          state_d     = StCheck;
        end
      end

      StCheck: begin
        if (hit) begin
          cpu_resp_valid = 1'b1;
          state_d        = StIdle;
          if (req_we_q) begin
            data_we      = 1'b1;
            tag_we       = 1'b1;
            data_wdata   = merged_line;
            tag_wdata    = req_tag;
            status_wdata = status_word(1'b1);
          end else begin
            cpu_resp_rdata = sel_word;
          end
        end else if (victim_dirty) begin
          victim_line_d = data_rdata;
          victim_tag_d  = tag_rdata;
          state_d       = StWb;
        end else begin
          state_d = StRefillReq;
        end
      end

      StWb: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {victim_tag_q, req_index};
        mem_req_wdata = victim_line_q;
        if (mem_req_ready) begin
          state_d = StRefillReq;
        end
      end

      StRefillReq: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_tag, req_index};
        if (mem_req_ready) begin
          state_d = StRefillWait;
        end
      end

      StRefillWait: begin
        if (mem_resp_valid) begin
          data_we        = 1'b1;
          tag_we         = 1'b1;
          data_wdata     = req_we_q ? merged_line : mem_resp_rdata;
          tag_wdata      = req_tag;
          status_wdata   = status_word(req_we_q);
          cpu_resp_valid = 1'b1;
          if (!req_we_q) begin
            cpu_resp_rdata = sel_word;
          end
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      req_we_q      <= 1'b0;
      req_addr_q    <= '0;
      req_wdata_q   <= '0;
      victim_line_q <= '0;
      victim_tag_q  <= '0;
    end else begin
      state_q       <= state_d;
      req_we_q      <= req_we_d;
      req_addr_q    <= req_addr_d;
      req_wdata_q   <= req_wdata_d;
      victim_line_q <= victim_line_d;
      victim_tag_q  <= victim_tag_d;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench: RAM and memory models around cache_controller, a directed table,
// hand-written reset/stall sequences and random traffic checked against a cache model.
module tb_cache_controller;

  logic         clk = 1'b0;
  logic         rst;
  logic         cpu_req_valid, cpu_req_we, cpu_req_ready, cpu_resp_valid;
  logic [26:0]  cpu_req_addr;
  logic [31:0]  cpu_req_wdata, cpu_resp_rdata;
  logic [9:0]   ram_addr;
  logic         tag_re, tag_we, data_re, data_we;
  logic [12:0]  tag_wdata, tag_rdata;
  logic [2:0]   status_wdata, status_rdata;
  logic [127:0] data_wdata, data_rdata;
  logic         mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid;
  logic [22:0]  mem_req_addr;
  logic [127:0] mem_req_wdata, mem_resp_rdata;

  always #5 clk = ~clk;

  cache_controller dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_we     (cpu_req_we),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_wdata  (cpu_req_wdata),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_rdata (cpu_resp_rdata),
    .ram_addr       (ram_addr),
    .tag_re         (tag_re),
    .tag_we         (tag_we),
    .tag_wdata      (tag_wdata),
    .status_wdata   (status_wdata),
    .tag_rdata      (tag_rdata),
    .status_rdata   (status_rdata),
    .data_re        (data_re),
    .data_we        (data_we),
    .data_wdata     (data_wdata),
    .data_rdata     (data_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
  );

  // Tag/status/data RAMs with registered outputs.
  logic         ram_clear;
  logic [12:0]  tag_mem  [1024];
  logic [2:0]   stat_mem [1024];
  logic [127:0] data_mem [1024];

  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 1024; i++) stat_mem[i] <= 3'b000;
    end else if (tag_we) begin
      tag_mem[ram_addr]  <= tag_wdata;
      stat_mem[ram_addr] <= status_wdata;
    end
    if (data_we) data_mem[ram_addr] <= data_wdata;
    if (tag_re) begin
      tag_rdata    <= tag_mem[ram_addr];
      status_rdata <= stat_mem[ram_addr];
    end
    if (data_re) data_rdata <= data_mem[ram_addr];
  end

  // Backing memory (environment) and the reference model's own view of memory.
  logic [127:0] tb_mem  [logic [22:0]];
  logic [127:0] ref_mem [logic [22:0]];

  function automatic logic [127:0] dflt(input logic [22:0] a);
    return {4'hA, 3'b0, a, 2'd3, 4'hA, 3'b0, a, 2'd2, 4'hA, 3'b0, a, 2'd1, 4'hA, 3'b0, a, 2'd0};
  endfunction

  function automatic logic [127:0] tb_read(input logic [22:0] a);
    if (tb_mem.exists(a)) return tb_mem[a];
    return dflt(a);
  endfunction

  function automatic logic [127:0] ref_read(input logic [22:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return dflt(a);
  endfunction

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Cache reference model: per-index valid/dirty/tag/line.
  bit           m_valid [1024];
  bit           m_dirty [1024];
  logic [12:0]  m_tag   [1024];
  logic [127:0] m_data  [1024];
  logic [31:0]  e_rdata;
  logic         e_wb, e_rf;
  logic [22:0]  e_wb_addr, e_rf_addr;
  logic [127:0] e_wb_data;
  logic [2:0]   e_status;

  task automatic model(input logic we, input logic [26:0] addr, input logic [31:0] wdata);
    logic [9:0]  idx;
    logic [12:0] tg;
    int          w;
    idx       = addr[13:4];
    tg        = addr[26:14];
    w         = int'(addr[3:2]);
    e_wb      = 1'b0;
    e_rf      = 1'b0;
    e_wb_addr = '0;
    e_wb_data = '0;
    e_rf_addr = '0;
    if (m_valid[idx] && m_tag[idx] == tg) begin
      e_status = we ? 3'b011 : 3'b000;
    end else begin
      if (m_valid[idx] && m_dirty[idx]) begin
        e_wb               = 1'b1;
        e_wb_addr          = {m_tag[idx], idx};
        e_wb_data          = m_data[idx];
        ref_mem[e_wb_addr] = m_data[idx];
      end
      e_rf         = 1'b1;
      e_rf_addr    = {tg, idx};
      m_data[idx]  = ref_read(e_rf_addr);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = 1'b0;
      e_status     = we ? 3'b011 : 3'b001;
    end
    if (we) begin
      m_data[idx][w*32 +: 32] = wdata;
      m_dirty[idx]            = 1'b1;
      e_rdata                 = '0;
    end else begin
      e_rdata = m_data[idx][w*32 +: 32];
    end
  endtask

  // Observations from one CPU transaction.
  logic         t_done, t_idle_ready, t_ready_low_ok, t_stable_ok;
  logic [31:0]  t_rdata;
  logic [2:0]   t_status;
  logic         t_wb_seen, t_rf_seen;
  logic [22:0]  t_wb_addr, t_rf_addr;
  logic [127:0] t_wb_data;
  int           t_lat, t_mreq_first;

  task automatic run_txn(input logic we, input logic [26:0] addr, input logic [31:0] wdata,
                         input int stall);
    logic         req_active;
    logic         h_we;
    logic [22:0]  h_addr;
    logic [127:0] h_wdata;
    int           stall_cnt, resp_cnt;
    t_done = 0; t_ready_low_ok = 1; t_stable_ok = 1; t_rdata = '0; t_status = '0;
    t_wb_seen = 0; t_rf_seen = 0; t_wb_addr = '0; t_rf_addr = '0; t_wb_data = '0;
    t_lat = -1; t_mreq_first = -1;
    req_active = 0; h_we = 0; h_addr = '0; h_wdata = '0; stall_cnt = 0; resp_cnt = -1;
    @(negedge clk);
    cpu_req_valid = 1'b1;
    cpu_req_we    = we;
    cpu_req_addr  = addr;
    cpu_req_wdata = wdata;
    #1 t_idle_ready = cpu_req_ready;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      cpu_req_valid  = 1'b0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = '0;
      if (resp_cnt > 0) resp_cnt--;
      if (resp_cnt == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = tb_read(t_rf_addr);
        resp_cnt       = -1;
      end
      #1;
      if (cpu_req_ready) t_ready_low_ok = 0;
      if (tag_we) t_status = status_wdata;
      if (cpu_resp_valid) begin
        t_rdata = cpu_resp_rdata;
        t_lat   = c;
        t_done  = 1;
        break;
      end
      if (mem_req_valid) begin
        if (t_mreq_first < 0) t_mreq_first = c;
        if (!req_active) begin
          req_active = 1; h_we = mem_req_we; h_addr = mem_req_addr; h_wdata = mem_req_wdata;
        end else if (mem_req_we !== h_we || mem_req_addr !== h_addr || mem_req_wdata !== h_wdata) begin
          t_stable_ok = 0;
        end
        if (stall_cnt < stall) begin
          stall_cnt++;
        end else begin
          mem_req_ready = 1'b1;
          stall_cnt     = 0;
          req_active    = 0;
          if (mem_req_we) begin
            t_wb_seen      = 1;
            t_wb_addr      = mem_req_addr;
            t_wb_data      = mem_req_wdata;
            tb_mem[mem_req_addr] = mem_req_wdata;
          end else begin
            t_rf_seen = 1;
            t_rf_addr = mem_req_addr;
            resp_cnt  = 1 + int'($urandom_range(0, 2));
          end
        end
      end
    end
  endtask

  task automatic check_txn(input string tg, input logic [31:0] rd, input logic wb,
                           input logic [22:0] wba, input logic [127:0] wbd, input logic rf,
                           input logic [22:0] rfa, input logic [2:0] st);
    chk({tg, ".done"}, 128'(t_done), 128'(1));
    chk({tg, ".idle_ready"}, 128'(t_idle_ready), 128'(1));
    chk({tg, ".busy_ready_low"}, 128'(t_ready_low_ok), 128'(1));
    chk({tg, ".mreq_stable"}, 128'(t_stable_ok), 128'(1));
    chk({tg, ".rdata"}, 128'(t_rdata), 128'(rd));
    chk({tg, ".status_w"}, 128'(t_status), 128'(st));
    chk({tg, ".wb_seen"}, 128'(t_wb_seen), 128'(wb));
    if (wb) begin
      chk({tg, ".wb_addr"}, 128'(t_wb_addr), 128'(wba));
      chk({tg, ".wb_data"}, t_wb_data, wbd);
    end
    chk({tg, ".refill_seen"}, 128'(t_rf_seen), 128'(rf));
    if (rf) begin
      chk({tg, ".refill_addr"}, 128'(t_rf_addr), 128'(rfa));
      chk({tg, ".mreq_start"}, 128'(t_mreq_first), 128'(2));
    end else begin
      chk({tg, ".hit_latency"}, 128'(t_lat), 128'(1));
    end
  endtask

  function automatic logic any_out();
    return |{cpu_resp_valid, cpu_resp_rdata, ram_addr, tag_re, tag_we, tag_wdata, status_wdata,
             data_re, data_we, data_wdata, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata};
  endfunction

  typedef struct {
    logic         we;
    logic [26:0]  addr;
    logic [31:0]  wdata;
    int           stall;
    logic [31:0]  rdata;
    logic         wb;
    logic [22:0]  wb_addr;
    logic [127:0] wb_data;
    logic         rf;
    logic [22:0]  rf_addr;
    logic [2:0]   status;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{1'b0, 27'h0000104, 32'h0, 0, 32'h22222222, 1'b0, 23'h0, 128'h0,
                1'b1, 23'h010, 3'b001};
    vecs[1] = '{1'b0, 27'h0000108, 32'h0, 0, 32'h33333333, 1'b0, 23'h0, 128'h0,
                1'b0, 23'h0, 3'b000};
    vecs[2] = '{1'b1, 27'h000010C, 32'hDEADBEEF, 0, 32'h0, 1'b0, 23'h0, 128'h0,
                1'b0, 23'h0, 3'b011};
    vecs[3] = '{1'b0, 27'h000010C, 32'h0, 0, 32'hDEADBEEF, 1'b0, 23'h0, 128'h0,
                1'b0, 23'h0, 3'b000};
    vecs[4] = '{1'b0, 27'h0004104, 32'h0, 5, 32'hA0001041, 1'b1, 23'h010,
                128'hDEADBEEF_33333333_22222222_11111111, 1'b1, 23'h410, 3'b001};
    vecs[5] = '{1'b1, 27'h0008208, 32'h12345678, 2, 32'h0, 1'b0, 23'h0, 128'h0,
                1'b1, 23'h820, 3'b011};
    vecs[6] = '{1'b0, 27'h0008208, 32'h0, 0, 32'h12345678, 1'b0, 23'h0, 128'h0,
                1'b0, 23'h0, 3'b000};

    for (int i = 0; i < 1024; i++) begin
      m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0; m_data[i] = '0;
    end
    tb_mem[23'h010]  = 128'h44444444_33333333_22222222_11111111;
    ref_mem[23'h010] = 128'h44444444_33333333_22222222_11111111;

    rst = 1'b1; ram_clear = 1'b1;
    cpu_req_valid = 0; cpu_req_we = 0; cpu_req_addr = '0; cpu_req_wdata = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0; ram_clear = 1'b0;
    #1;
    chk("reset.ready", 128'(cpu_req_ready), 128'(1));
    chk("reset.outputs_zero", 128'(any_out()), 128'(0));

    for (int i = 0; i < 7; i++) begin
      model(vecs[i].we, vecs[i].addr, vecs[i].wdata);
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].stall);
      check_txn($sformatf("vec%0d", i), vecs[i].rdata, vecs[i].wb, vecs[i].wb_addr,
                vecs[i].wb_data, vecs[i].rf, vecs[i].rf_addr, vecs[i].status);
    end

    // Reset while waiting for a refill; a late response must be ignored.
    begin
      bit got_req;
      got_req = 0;
      @(negedge clk);
      cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 27'h0003FF0;
      @(negedge clk);
      cpu_req_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        if (mem_req_valid && !mem_req_we) begin
          mem_req_ready = 1'b1;
          got_req       = 1;
          break;
        end
      end
      chk("rstmid.refill_req", 128'(got_req), 128'(1));
      @(negedge clk);
      mem_req_ready = 1'b0;
      rst           = 1'b1;
      #1 chk("rstmid.wait_no_resp", 128'(cpu_resp_valid), 128'(0));
      @(negedge clk);
      rst            = 1'b0;
      mem_resp_valid = 1'b1;
      mem_resp_rdata = {4{32'hBAD0BAD0}};
      #1;
      chk("rstmid.ready", 128'(cpu_req_ready), 128'(1));
      chk("rstmid.outputs_zero", 128'(any_out()), 128'(0));
      @(negedge clk);
      #1;
      chk("rstmid.late_resp_ignored", 128'({tag_we, data_we, cpu_resp_valid}), 128'(0));
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_resp_rdata = '0;
    end

    // Random traffic over a few indices and tags to force hits, clean and dirty misses.
    for (int n = 0; n < 60; n++) begin
      logic        we;
      logic [9:0]  idx;
      logic [12:0] tg;
      logic [26:0] addr;
      logic [31:0] wd;
      case ($urandom_range(0, 3))
        0:       idx = 10'h010;
        1:       idx = 10'h011;
        2:       idx = 10'h020;
        default: idx = 10'h3FF;
      endcase
      tg   = 13'($urandom_range(0, 3));
      addr = {tg, idx, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      we   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      model(we, addr, wd);
      run_txn(we, addr, wd, int'($urandom_range(0, 3)));
      check_txn($sformatf("rnd%0d", n), e_rdata, e_wb, e_wb_addr, e_wb_data, e_rf, e_rf_addr,
                e_status);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
